// File: rtl/debug_mem_bridge.sv
// Host-side loader/dumper: parses framed command bytes and performs burst word
// writes/reads on the data or instruction BRAM debug port 2, answering with bytes.
module debug_mem_bridge #(
   parameter int unsigned READ_LAT       = 1,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic        CPU_CLK,
   input  logic        CPU_RST,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [7:0]  rsp_data,
   output logic        busy,
   output logic [31:0] CPU_Debug_DataRAM_A2,
   output logic [31:0] CPU_Debug_DataRAM_WD2,
   output logic [3:0]  CPU_Debug_DataRAM_WE2,
   input  logic [31:0] CPU_Debug_DataRAM_RD2,
   output logic [31:0] CPU_Debug_InstRAM_A2,
   output logic [31:0] CPU_Debug_InstRAM_WD2,
   output logic [3:0]  CPU_Debug_InstRAM_WE2,
   input  logic [31:0] CPU_Debug_InstRAM_RD2
);

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_CNT, S_WDATA, S_WSTROBE, S_RADDR, S_RWAIT, S_RSEND, S_RESP
   } state_t;

   localparam logic [7:0]  OP_WD    = 8'h57;
   localparam logic [7:0]  OP_WI    = 8'h77;
   localparam logic [7:0]  OP_RD    = 8'h52;
   localparam logic [7:0]  OP_RI    = 8'h72;
   localparam logic [7:0]  R_ACK    = 8'h4B;
   localparam logic [7:0]  R_ERR    = 8'h45;
   localparam logic [7:0]  R_TO     = 8'h54;
   localparam logic [2:0]  LAT_LAST = 3'(READ_LAT - 1);
   localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] a2_q, a2_d;
   logic [31:0] word_q, word_d;
   logic [31:0] tcnt_q, tcnt_d;
   logic [15:0] cnt_q, cnt_d;
   logic [1:0]  bidx_q, bidx_d;
   logic [2:0]  lat_q, lat_d;
   logic [7:0]  code_q, code_d;
   logic        wr_q, wr_d;
   logic        inst_q, inst_d;

   logic        cmd_fire, rsp_fire, in_frame, to_hit, wstrobe;
   logic [15:0] cnt_shift;

   assign in_frame  = (state_q == S_ADDR) || (state_q == S_CNT) || (state_q == S_WDATA);
   assign cmd_ready = !CPU_RST && (in_frame || state_q == S_IDLE);
   assign rsp_valid = !CPU_RST && (state_q == S_RSEND || state_q == S_RESP);
   assign busy      = !CPU_RST && (state_q != S_IDLE);
   assign cmd_fire  = cmd_valid && cmd_ready;
   assign rsp_fire  = rsp_valid && rsp_ready;
   assign to_hit    = (TIMEOUT_CYCLES != 0) && (tcnt_q == TO_LAST);
   assign cnt_shift = {cnt_q[7:0], cmd_data};
   assign wstrobe   = !CPU_RST && (state_q == S_WSTROBE);

   // Read words leave MSB first by shifting word_q left after each accepted byte.
   always_comb begin
      rsp_data = '0;
      if (!CPU_RST && state_q == S_RSEND) rsp_data = word_q[31:24];
      else if (!CPU_RST && state_q == S_RESP) rsp_data = code_q;
   end

   assign CPU_Debug_DataRAM_A2  = (!CPU_RST && !inst_q) ? a2_q : '0;
   assign CPU_Debug_DataRAM_WD2 = (wstrobe && !inst_q) ? word_q : '0;
   assign CPU_Debug_DataRAM_WE2 = (wstrobe && !inst_q) ? 4'hF : 4'h0;
   assign CPU_Debug_InstRAM_A2  = (!CPU_RST && inst_q) ? a2_q : '0;
   assign CPU_Debug_InstRAM_WD2 = (wstrobe && inst_q) ? word_q : '0;
   assign CPU_Debug_InstRAM_WE2 = (wstrobe && inst_q) ? 4'hF : 4'h0;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      a2_d    = a2_q;
      word_d  = word_q;
      cnt_d   = cnt_q;
      bidx_d  = bidx_q;
      lat_d   = lat_q;
      code_d  = code_q;
      wr_d    = wr_q;
      inst_d  = inst_q;
      tcnt_d  = '0;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_fire) begin
               bidx_d = '0;
               case (cmd_data)
                  OP_WD:   begin wr_d = 1'b1; inst_d = 1'b0; state_d = S_ADDR; end
                  OP_WI:   begin wr_d = 1'b1; inst_d = 1'b1; state_d = S_ADDR; end
                  OP_RD:   begin wr_d = 1'b0; inst_d = 1'b0; state_d = S_ADDR; end
                  OP_RI:   begin wr_d = 1'b0; inst_d = 1'b1; state_d = S_ADDR; end
                  default: begin code_d = R_ERR; state_d = S_RESP; end
               endcase
            end
         end
         S_ADDR: begin
            if (cmd_fire) begin
               addr_d = {addr_q[23:0], cmd_data};
               bidx_d = bidx_q + 2'd1;
               if (bidx_q == 2'd3) begin
                  addr_d[1:0] = 2'b00;
                  bidx_d      = '0;
                  state_d     = S_CNT;
               end
            end
         end
         S_CNT: begin
            if (cmd_fire) begin
               cnt_d  = cnt_shift;
               bidx_d = bidx_q + 2'd1;
               if (bidx_q == 2'd1) begin
                  bidx_d = '0;
                  if (cnt_shift == 16'd0) begin
                     code_d  = R_ACK;
                     state_d = S_RESP;
                  end else if (wr_q) begin
                     state_d = S_WDATA;
                  end else begin
                     a2_d    = addr_q;
                     state_d = S_RADDR;
                  end
               end
            end
         end
         S_WDATA: begin
            if (cmd_fire) begin
               word_d = {word_q[23:0], cmd_data};
               bidx_d = bidx_q + 2'd1;
               if (bidx_q == 2'd3) begin
                  bidx_d  = '0;
                  a2_d    = addr_q;
                  state_d = S_WSTROBE;
               end
            end
         end
         S_WSTROBE: begin
            // a2_q keeps the strobed address; only the running address advances.
            addr_d = addr_q + 32'd4;
            cnt_d  = cnt_q - 16'd1;
            if (cnt_q == 16'd1) begin
               code_d  = R_ACK;
               state_d = S_RESP;
            end else begin
               state_d = S_WDATA;
            end
         end
         S_RADDR: begin
            lat_d   = '0;
            state_d = S_RWAIT;
         end
         S_RWAIT: begin
            if (lat_q == LAT_LAST) begin
               word_d  = inst_q ? CPU_Debug_InstRAM_RD2 : CPU_Debug_DataRAM_RD2;
               bidx_d  = '0;
               state_d = S_RSEND;
            end else begin
               lat_d = lat_q + 3'd1;
            end
         end
         S_RSEND: begin
            if (rsp_fire) begin
               word_d = {word_q[23:0], 8'h00};
               bidx_d = bidx_q + 2'd1;
               if (bidx_q == 2'd3) begin
                  addr_d = addr_q + 32'd4;
                  cnt_d  = cnt_q - 16'd1;
                  if (cnt_q == 16'd1) begin
                     code_d  = R_ACK;
                     state_d = S_RESP;
                  end else begin
                     a2_d    = addr_q + 32'd4;
                     state_d = S_RADDR;
                  end
               end
            end
         end
         S_RESP: begin
            if (rsp_fire) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Inter-byte idle timer; cleared by any accepted byte or outside frame states.
      if (in_frame && !cmd_fire) begin
         if (to_hit) begin
            code_d  = R_TO;
            state_d = S_RESP;
         end else begin
            tcnt_d = tcnt_q + 32'd1;
         end
      end
   end

   always_ff @(posedge CPU_CLK) begin
      if (CPU_RST) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         a2_q    <= '0;
         word_q  <= '0;
         tcnt_q  <= '0;
         cnt_q   <= '0;
         bidx_q  <= '0;
         lat_q   <= '0;
         code_q  <= '0;
         wr_q    <= 1'b0;
         inst_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         a2_q    <= a2_d;
         word_q  <= word_d;
         tcnt_q  <= tcnt_d;
         cnt_q   <= cnt_d;
         bidx_q  <= bidx_d;
         lat_q   <= lat_d;
         code_q  <= code_d;
         wr_q    <= wr_d;
         inst_q  <= inst_d;
      end
   end

endmodule

// File: tb/tb_debug_mem_bridge.sv
// Scoreboard bench for debug_mem_bridge: two instances (READ_LAT 1 and 3) fed the
// same command stream, each with its own BRAM model and response/write monitor.
module tb_debug_mem_bridge;

   typedef struct packed {
      logic        inst;
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       chk_rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic [7:0] cmd_data = 8'h00;
   logic       rsp_ready = 1'b1;
   bit         rand_rdy = 1'b0;
   int         max_gap = 0;
   int         errs = 0;
   int         checks = 0;

   logic [1:0] rdy_v, busy_v, rv_v;

   logic [7:0]  exp_rsp [2][$];
   wr_t         exp_wr  [2][$];
   logic [31:0] payload [$];
   bit [31:0]   mdm [bit [31:0]];
   bit [31:0]   mim [bit [31:0]];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      rsp_ready = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
   end

   task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   task automatic fail(input string nm, input int val);
      checks++;
      errs++;
      $display("FAIL %s: value %0d (t=%0t)", nm, val, $time);
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int unsigned LAT = (g == 0) ? 1 : 3;
      logic        cr, rv, bz;
      logic [7:0]  rd;
      logic [31:0] da2, dwd, drd, ia2, iwd, ird;
      logic [3:0]  dwe, iwe;
      logic [31:0] dm [256];
      logic [31:0] im [256];
      logic [31:0] dh [LAT];
      logic [31:0] ih [LAT];
      logic        dstable, istable;
      logic        pv_stall;
      logic [7:0]  pv_data;
      wr_t         w;

      debug_mem_bridge #(.READ_LAT(LAT), .TIMEOUT_CYCLES(20)) u_dut (
         .CPU_CLK(clk), .CPU_RST(rst),
         .cmd_valid(cmd_valid), .cmd_ready(cr), .cmd_data(cmd_data),
         .rsp_valid(rv), .rsp_ready(rsp_ready), .rsp_data(rd), .busy(bz),
         .CPU_Debug_DataRAM_A2(da2), .CPU_Debug_DataRAM_WD2(dwd),
         .CPU_Debug_DataRAM_WE2(dwe), .CPU_Debug_DataRAM_RD2(drd),
         .CPU_Debug_InstRAM_A2(ia2), .CPU_Debug_InstRAM_WD2(iwd),
         .CPU_Debug_InstRAM_WE2(iwe), .CPU_Debug_InstRAM_RD2(ird)
      );

      assign rdy_v[g]  = cr;
      assign busy_v[g] = bz;
      assign rv_v[g]   = rv;

      // BRAM model: RD is the word at the address seen LAT edges ago, and is
      // poisoned unless A2 has not moved over that whole window.
      always @(posedge clk) begin
         if (dwe == 4'hF) dm[da2[9:2]] <= dwd;
         if (iwe == 4'hF) im[ia2[9:2]] <= iwd;
         dh[0] <= da2;
         ih[0] <= ia2;
         for (int i = 1; i < LAT; i++) begin
            dh[i] <= dh[i-1];
            ih[i] <= ih[i-1];
         end
      end
      always_comb begin
         dstable = 1'b1;
         istable = 1'b1;
         for (int i = 0; i < LAT; i++) begin
            if (dh[i] != da2) dstable = 1'b0;
            if (ih[i] != ia2) istable = 1'b0;
         end
      end
      assign drd = dstable ? dm[dh[LAT-1][9:2]] : 32'hBAD0_BAD0;
      assign ird = istable ? im[ih[LAT-1][9:2]] : 32'hBAD1_BAD1;

      always @(negedge clk) begin
         if (rst) begin
            pv_stall = 1'b0;
            if (chk_rst) begin
               cmp($sformatf("rst_cmd_ready%0d", g), {31'd0, cr}, 32'd0);
               cmp($sformatf("rst_rsp_valid%0d", g), {31'd0, rv}, 32'd0);
               cmp($sformatf("rst_rsp_data%0d", g), {24'd0, rd}, 32'd0);
               cmp($sformatf("rst_busy%0d", g), {31'd0, bz}, 32'd0);
               cmp($sformatf("rst_a2%0d", g), da2 | ia2, 32'd0);
               cmp($sformatf("rst_wd2%0d", g), dwd | iwd, 32'd0);
               cmp($sformatf("rst_we2%0d", g), {28'd0, dwe | iwe}, 32'd0);
            end
         end else begin
            if (pv_stall) begin
               cmp($sformatf("rsp_hold_valid%0d", g), {31'd0, rv}, 32'd1);
               cmp($sformatf("rsp_hold_data%0d", g), {24'd0, rd}, {24'd0, pv_data});
            end
            if (rv && rsp_ready) begin
               if (exp_rsp[g].size() == 0) fail($sformatf("rsp_unexpected%0d byte", g), int'(rd));
               else cmp($sformatf("rsp_byte%0d", g), {24'd0, rd}, {24'd0, exp_rsp[g].pop_front()});
            end
            pv_stall = rv && !rsp_ready;
            pv_data  = rd;
            if (dwe != 4'h0 || iwe != 4'h0) begin
               if (exp_wr[g].size() == 0) begin
                  fail($sformatf("wr_unexpected%0d addr", g), int'(da2 | ia2));
               end else begin
                  w = exp_wr[g].pop_front();
                  cmp($sformatf("wr_ram%0d", g), {31'd0, iwe != 4'h0}, {31'd0, w.inst});
                  cmp($sformatf("wr_addr%0d", g), w.inst ? ia2 : da2, w.addr);
                  cmp($sformatf("wr_data%0d", g), w.inst ? iwd : dwd, w.data);
                  cmp($sformatf("wr_we%0d", g), {28'd0, w.inst ? iwe : dwe}, 32'hF);
                  cmp($sformatf("wr_other_a2%0d", g), w.inst ? da2 : ia2, 32'd0);
                  cmp($sformatf("wr_other_we%0d", g), {28'd0, w.inst ? dwe : iwe}, 32'd0);
               end
            end
         end
      end
   end

   task automatic push_rsp(input logic [7:0] b);
      exp_rsp[0].push_back(b);
      exp_rsp[1].push_back(b);
   endtask

   task automatic send(input logic [7:0] b);
      int n;
      n = 0;
      cmd_valid = 1'b1;
      cmd_data  = b;
      forever begin
         @(negedge clk);
         if (rdy_v == 2'b11) break;
         n++;
         if (n > 300) begin
            fail("cmd_ready_wait_expired", n);
            break;
         end
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_word(input logic [31:0] t);
      send(t[31:24]);
      send(t[23:16]);
      send(t[15:8]);
      send(t[7:0]);
   endtask

   task automatic hdr(input logic [7:0] op, input logic [31:0] a, input logic [15:0] n);
      send(op);
      send_word(a);
      send(n[15:8]);
      send(n[7:0]);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      forever begin
         @(negedge clk);
         if (busy_v == 2'b00 && exp_rsp[0].size() == 0 && exp_rsp[1].size() == 0 &&
             exp_wr[0].size() == 0 && exp_wr[1].size() == 0) break;
         n++;
         if (n > 3000) begin
            fail("drain_wait_expired", n);
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Expected writes: aligned start, +4 per word with 32-bit wrap.
   task automatic expect_write(input bit inst, input logic [31:0] a);
      wr_t w;
      w.inst = inst;
      w.addr = a;
      w.data = payload[0];
      exp_wr[0].push_back(w);
      exp_wr[1].push_back(w);
      if (inst) mim[a] = payload[0];
      else mdm[a] = payload[0];
      void'(payload.pop_front());
   endtask

   task automatic wr_frame(input bit inst, input logic [31:0] a, input int n);
      logic [31:0] words [$];
      logic [31:0] base;
      words = payload;
      base  = {a[31:2], 2'b00};
      for (int i = 0; i < n; i++) expect_write(inst, base + 32'(4 * i));
      push_rsp(8'h4B);
      hdr(inst ? 8'h77 : 8'h57, a, 16'(n));
      for (int i = 0; i < n; i++) send_word(words[i]);
      wait_done();
   endtask

   task automatic rd_frame(input bit inst, input logic [31:0] a, input int n);
      logic [31:0] base, x, d;
      base = {a[31:2], 2'b00};
      for (int i = 0; i < n; i++) begin
         x = base + 32'(4 * i);
         if (inst) d = mim.exists(x) ? mim[x] : 32'd0;
         else d = mdm.exists(x) ? mdm[x] : 32'd0;
         push_rsp(d[31:24]);
         push_rsp(d[23:16]);
         push_rsp(d[15:8]);
         push_rsp(d[7:0]);
      end
      push_rsp(8'h4B);
      hdr(inst ? 8'h72 : 8'h52, a, 16'(n));
      wait_done();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete (errors=%0d)", errs);
      $fatal(1, "watchdog");
   end

   initial begin
      int          n, kind;
      bit          inst;
      logic [31:0] a;
      logic [7:0]  op;

      repeat (3) @(posedge clk);
      #1;
      rst     = 1'b0;
      chk_rst = 1'b0;

      payload = '{32'hDEADBEEF, 32'h01020304};
      wr_frame(1'b0, 32'h10, 2);
      rd_frame(1'b0, 32'h10, 2);

      payload = '{32'h11111111, 32'h22222222};
      wr_frame(1'b1, 32'hFFFFFFFE, 2);

      push_rsp(8'h45);
      send(8'h33);
      wait_done();
      rd_frame(1'b0, 32'h0, 0);

      // Stalled write payload: 20 idle cycles then 'T', nothing written.
      push_rsp(8'h54);
      hdr(8'h57, 32'h0, 16'd1);
      send(8'hAA);
      n = 0;
      while (rv_v[0] !== 1'b1 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      cmp("timeout_idle_cycles", 32'(n), 32'd20);
      wait_done();
      rd_frame(1'b0, 32'h10, 1);

      rand_rdy = 1'b1;
      rd_frame(1'b0, 32'h10, 2);
      rand_rdy = 1'b0;

      // Reset mid-write: first word lands, second is dropped along with the ack.
      payload = '{32'hCAFEF00D};
      expect_write(1'b0, 32'h40);
      hdr(8'h57, 32'h40, 16'd2);
      send_word(32'hCAFEF00D);
      send(8'h99);
      send(8'h88);
      chk_rst = 1'b1;
      rst     = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst     = 1'b0;
      chk_rst = 1'b0;
      cmp("rst_pending_rsp", 32'(exp_rsp[0].size() + exp_rsp[1].size()), 32'd0);
      cmp("rst_pending_wr", 32'(exp_wr[0].size() + exp_wr[1].size()), 32'd0);
      cmp("rst_busy_after", {30'd0, busy_v}, 32'd0);
      rd_frame(1'b0, 32'h40, 1);

      for (int it = 0; it < 14; it++) begin
         kind     = $urandom_range(0, 3);
         inst     = 1'($urandom_range(0, 1));
         a        = 32'($urandom_range(0, 32'h3E0));
         n        = $urandom_range(0, 3);
         max_gap  = $urandom_range(0, 3);
         rand_rdy = 1'($urandom_range(0, 1));
         if (kind == 3) begin
            do op = 8'($urandom_range(0, 255));
            while (op == 8'h57 || op == 8'h77 || op == 8'h52 || op == 8'h72);
            push_rsp(8'h45);
            send(op);
            wait_done();
         end else begin
            payload.delete();
            for (int i = 0; i < n; i++) payload.push_back($urandom);
            wr_frame(inst, a, n);
            rd_frame(inst, a, n);
         end
      end
      max_gap  = 0;
      rand_rdy = 1'b0;
      rd_frame(1'b1, 32'hFFFFFFFC, 1);

      cmp("final_pending", 32'(exp_rsp[0].size() + exp_rsp[1].size() +
                               exp_wr[0].size() + exp_wr[1].size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
